alu_cmd_sequencer: RTL and testbench

//   Command-side driver for the 4-bit registered ALU. Accepts one operation at a

---
 rtl/alu_cmd_sequencer.sv | 117 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command/response front end for the registered ALU: issues one operation at a time,
// waits out the ALU pipeline, returns the captured result and keeps saturating statistics.
module alu_cmd_sequencer #(
  parameter int W           = 4,
  parameter int ALU_LATENCY = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [1:0]       cmd_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [1:0]       rsp_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] div0_count
);

  localparam int CW = $clog2(ALU_LATENCY + 1);
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic          accept, capture, consume;

  always_comb begin
    state_next = state_reg;
    cmd_ready  = (state_reg == IDLE);
    accept     = 1'b0;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          consume    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= '0;
      op_count   <= '0;
      div0_count <= '0;
    end else begin
      state_reg <= state_next;
      // Operands stay on the ALU inputs until the next accept, even while idle.
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_op;
        rsp_op     <= cmd_op;
        cnt_reg    <= CW'(ALU_LATENCY);
      end
      if (state_reg == WAIT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_cout   <= alu_cout;
        rsp_zero   <= alu_zero;
        rsp_valid  <= 1'b1;
      end
      if (consume) begin
        rsp_valid <= 1'b0;
        if (op_count != '1) begin
          op_count <= op_count + CNT_W'(1);
        end
        if (rsp_op == OP_DIV && rsp_cout && div0_count != '1) begin
          div0_count <= div0_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: registered ALU stub, transaction-level reference model,
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_alu_cmd_sequencer;

  localparam int W     = 4;
  localparam int LAT   = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [W-1:0]     cmd_a, cmd_b, rsp_result, alu_a, alu_b, alu_result;
  logic [1:0]       cmd_op, rsp_op, alu_opcode;
  logic             rsp_cout, rsp_zero, alu_cout, alu_zero, busy;
  logic [CNT_W-1:0] op_count, div0_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.W(W), .ALU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count), .div0_count(div0_count)
  );

  // Arithmetic of the 4-bit ALU: returns {cout, zero, result}.
  function automatic logic [W+1:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    int   r;
    logic c;
    r = 0;
    c = 1'b0;
    case (op)
      2'd0: begin r = a + b; c = (r >= (1 << W)); end
      2'd1: begin r = a - b; c = (a < b); end
      2'd2: begin r = a * b; c = (r >= (1 << W)); end
      default: begin
        if (b == 0) begin r = 0; c = 1'b1; end
        else        begin r = a / b; c = 1'b0; end
      end
    endcase
    r = r & ((1 << W) - 1);
    return {c, (r == 0), r[W-1:0]};
  endfunction

  // ALU stub with LAT register stages.
  logic [W+1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= alu_ref(alu_a, alu_b, alu_opcode);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {alu_cout, alu_zero, alu_result} = pipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, response due LAT+1 edges after accept.
  bit         m_inflight, m_valid;
  int         m_age, m_ops, m_div0;
  logic [W-1:0] m_a, m_b, m_res;
  logic [1:0] m_op, m_rsp_op;
  logic       m_cout, m_zero;
  logic [W+1:0] m_exp;

  task automatic model_reset();
    m_inflight = 0; m_valid = 0; m_age = 0; m_ops = 0; m_div0 = 0;
    m_a = '0; m_b = '0; m_op = '0; m_rsp_op = '0;
    m_res = '0; m_cout = 1'b0; m_zero = 1'b0; m_exp = '0;
  endtask

  task automatic model_edge();
    if (m_inflight && m_valid) begin
      if (rsp_ready) begin
        m_ops++;
        if (m_rsp_op == 2'd3 && m_cout) m_div0++;
        m_inflight = 0;
        m_valid    = 0;
        $display("[TB] rsp op=%0d result=%0d cout=%0d zero=%0d", m_rsp_op, m_res, m_cout, m_zero);
      end
    end else if (m_inflight) begin
      m_age++;
      if (m_age == LAT + 1) begin
        m_valid = 1;
        {m_cout, m_zero, m_res} = m_exp;
      end
    end else if (cmd_valid) begin
      m_inflight = 1;
      m_age      = 0;
      m_a = cmd_a; m_b = cmd_b; m_op = cmd_op; m_rsp_op = cmd_op;
      m_exp = alu_ref(cmd_a, cmd_b, cmd_op);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) model_edge();
  endtask

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, int'(!m_inflight));
      chk("busy", busy, int'(m_inflight));
      chk("rsp_valid", rsp_valid, int'(m_valid));
      chk("rsp_result", rsp_result, int'(m_res));
      chk("rsp_cout", rsp_cout, int'(m_cout));
      chk("rsp_zero", rsp_zero, int'(m_zero));
      chk("rsp_op", rsp_op, int'(m_rsp_op));
      chk("alu_a", alu_a, int'(m_a));
      chk("alu_b", alu_b, int'(m_b));
      chk("alu_opcode", alu_opcode, int'(m_op));
      chk("op_count", op_count, sat(m_ops));
      chk("div0_count", div0_count, sat(m_div0));
    end
  end

  task automatic directed(input int a, input int b, input int op,
                          input int er, input int ec, input int ez);
    int n;
    cmd_a = W'(a); cmd_b = W'(b); cmd_op = 2'(op); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("lit_latency", n, LAT + 1);
    chk("lit_result", rsp_result, er);
    chk("lit_cout", rsp_cout, ec);
    chk("lit_zero", rsp_zero, ez);
    chk("lit_rsp_op", rsp_op, op);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    #1 rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_op_count", op_count, 0);

    directed(9, 8, 0, 1, 1, 0);
    directed(3, 5, 1, 14, 1, 0);
    directed(4, 4, 2, 0, 1, 1);
    directed(7, 0, 3, 0, 1, 1);
    chk("div0_after_7div0", div0_count, 1);
    chk("ops_after_7div0", op_count, 4);
    directed(9, 2, 3, 4, 0, 0);
    chk("div0_after_9div2", div0_count, 1);
    chk("ops_after_9div2", op_count, 5);

    // Backpressure: response held, new commands ignored.
    cmd_a = 4'd5; cmd_b = 4'd6; cmd_op = 2'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("bp_latency", n, LAT + 1);
    cmd_a = 4'd15; cmd_b = 4'd15; cmd_op = 2'd2; cmd_valid = 1'b1;
    repeat (5) begin
      step();
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 11);
      chk("bp_alu_a", alu_a, 5);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("bp_cmd_ready_after", cmd_ready, 1);
    chk("bp_rsp_valid_after", rsp_valid, 0);
    chk("bp_op_count", op_count, 6);

    // Reset while waiting on the ALU.
    cmd_a = 4'd2; cmd_b = 4'd3; cmd_op = 2'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_alu_a", alu_a, 0);
    chk("rstw_op_count", op_count, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    step();
    rst = 1'b0;
    directed(2, 3, 2, 6, 0, 0);
    chk("rstw_op_count_after", op_count, 1);

    // Randomized traffic.
    repeat (800) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = W'($urandom);
      cmd_b     = W'($urandom);
      cmd_op    = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Saturation run from a fresh reset.
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (m_ops < (1 << CNT_W) + 2 && n < 4000) begin
      cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_op = 2'($urandom);
      step();
      n++;
    end
    cmd_valid = 1'b0;
    chk("sat_done_in_budget", int'(n < 4000), 1);
    step();
    chk("sat_op_count", op_count, 255);
    repeat (3) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
